eth_rx_frame_writer: RTL and testbench

Receive-side framing stage between the RGMII byte-stream interface (rx_dv/rx_er/rxd, already converted to one byte per clk) and the RX byte FIFO. It strips preamble and SFD and writes every frame byte, FCS included, into the FIFO. Once the last FCS byte has been written, it emits a delayed one-cycle frame_done pulse. It also reports the frame length and error status alongside that pulse. The downstream CRC32 stream checker consumes the FIFO bytes and the frame_done pulse.

---
 rtl/eth_rx_frame_writer.sv | 211 +++++++++++++++++++++
 tb/tb_eth_rx_frame_writer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_writer.sv
// Receive framing stage: strips preamble/SFD, writes frame bytes (FCS included) to the RX FIFO
// and reports length/status with a delayed frame_done pulse. Optional counters: ETH_RX_STATS_EN.
module eth_rx_frame_writer #(
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518,
    parameter int LEN_W      = 11,
    parameter int DONE_DELAY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_dv,
    input  logic             rx_er,
    input  logic [7:0]       rxd,
    output logic [7:0]       fifo_din,
    output logic             fifo_we,
    input  logic             fifo_full,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             st_runt,
    output logic             st_giant,
    output logic             st_rxer,
    output logic             st_ovf,
    output logic [15:0]      cnt_good,
    output logic [15:0]      cnt_bad
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        PRE       = 2'd2,
        DATA      = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_SAT   = '1;
    localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
    localparam logic [4:0]       DLY_LOAD  = 5'(DONE_DELAY - 1);
    localparam bit               DLY_ONE   = (DONE_DELAY == 1);

    state_t           state_r;
    logic [LEN_W-1:0] cnt_r;
    logic             rxer_r;
    logic             ovf_r;

    logic             pend_v_r;
    logic [4:0]       dly_r;
    logic [LEN_W-1:0] pend_len_r;
    logic [3:0]       pend_st_r;

    logic [LEN_W-1:0] cnt_inc_s;
    logic             data_byte_s;
    logic             end_s;
    logic             wr_s;
    logic [3:0]       end_st_s;
    logic             fire_s;
    logic [LEN_W-1:0] fire_len_s;
    logic [3:0]       fire_st_s;

    // Per-cycle decode of the byte stream and of the done-delay pipeline
    always_comb begin
        cnt_inc_s   = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + LEN_W'(1);
        data_byte_s = (state_r == DATA) && rx_dv;
        end_s       = (state_r == DATA) && !rx_dv;
        wr_s        = data_byte_s && !fifo_full && (cnt_inc_s <= MAX_L);
        end_st_s    = {(cnt_r < MIN_L), (cnt_r > MAX_L), rxer_r, ovf_r};
        // A one-cycle delay fires straight from the end-of-frame cycle, bypassing the snapshot
        if (DLY_ONE) begin
            fire_s     = end_s;
            fire_len_s = cnt_r;
            fire_st_s  = end_st_s;
        end else begin
            fire_s     = pend_v_r && (dly_r == 5'd1);
            fire_len_s = pend_len_r;
            fire_st_s  = pend_st_r;
        end
    end

    // Framing FSM, byte counter, error flags and registered FIFO write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= WAIT_IDLE;
            cnt_r    <= '0;
            rxer_r   <= 1'b0;
            ovf_r    <= 1'b0;
            fifo_we  <= 1'b0;
            fifo_din <= 8'h00;
        end else begin
            fifo_we <= wr_s;
            if (wr_s) begin
                fifo_din <= rxd;
            end else begin
                fifo_din <= fifo_din;
            end
            case (state_r)
                WAIT_IDLE: begin
                    if (!rx_dv) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                IDLE: begin
                    if (rx_dv && (rxd == 8'h55)) begin
                        state_r <= PRE;
                    end else if (rx_dv) begin
                        state_r <= WAIT_IDLE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRE: begin
                    if (!rx_dv) begin
                        state_r <= IDLE;
                    end else if (rxd == 8'h55) begin
                        state_r <= PRE;
                    end else if (rxd == 8'hD5) begin
                        state_r <= DATA;
                        cnt_r   <= '0;
                        rxer_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                DATA: begin
                    if (rx_dv) begin
                        cnt_r <= cnt_inc_s;
                        if (rx_er) begin
                            rxer_r <= 1'b1;
                        end else begin
                            rxer_r <= rxer_r;
                        end
                        if (fifo_full) begin
                            ovf_r <= 1'b1;
                        end else begin
                            ovf_r <= ovf_r;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= WAIT_IDLE;
                end
            endcase
        end
    end

    // End-of-frame snapshot and done delay; result outputs update only on the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v_r   <= 1'b0;
            dly_r      <= 5'd0;
            pend_len_r <= '0;
            pend_st_r  <= 4'd0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            st_runt    <= 1'b0;
            st_giant   <= 1'b0;
            st_rxer    <= 1'b0;
            st_ovf     <= 1'b0;
        end else begin
            if (end_s) begin
                pend_len_r <= cnt_r;
                pend_st_r  <= end_st_s;
                pend_v_r   <= !DLY_ONE;
                dly_r      <= DLY_LOAD;
            end else if (pend_v_r) begin
                dly_r <= dly_r - 5'd1;
                if (dly_r == 5'd1) begin
                    pend_v_r <= 1'b0;
                end else begin
                    pend_v_r <= 1'b1;
                end
            end else begin
                pend_v_r <= 1'b0;
            end
            frame_done <= fire_s;
            if (fire_s) begin
                frame_len <= fire_len_s;
                {st_runt, st_giant, st_rxer, st_ovf} <= fire_st_s;
            end else begin
                frame_len <= frame_len;
                {st_runt, st_giant, st_rxer, st_ovf} <= {st_runt, st_giant, st_rxer, st_ovf};
            end
        end
    end

`ifdef ETH_RX_STATS_EN
    // Saturating good/bad frame counters, visible in the frame_done cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_good <= 16'd0;
            cnt_bad  <= 16'd0;
        end else if (fire_s) begin
            if (fire_st_s != 4'd0) begin
                cnt_bad <= (cnt_bad == 16'hFFFF) ? cnt_bad : cnt_bad + 16'd1;
            end else begin
                cnt_good <= (cnt_good == 16'hFFFF) ? cnt_good : cnt_good + 16'd1;
            end
        end else begin
            cnt_good <= cnt_good;
            cnt_bad  <= cnt_bad;
        end
    end
`else
    assign cnt_good = 16'd0;
    assign cnt_bad  = 16'd0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Self-checking bench for eth_rx_frame_writer: directed and random frames checked against a
// queue-based reference model of written bytes, length, status and done timing.
module tb_eth_rx_frame_writer;
    localparam int D    = 4;
    localparam int MINL = 64;
    localparam int MAXL = 1518;
    localparam int LW   = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_dv = 1'b0;
    logic          rx_er = 1'b0;
    logic [7:0]    rxd = 8'h00;
    logic          fifo_full = 1'b0;
    logic [7:0]    fifo_din;
    logic          fifo_we;
    logic          frame_done;
    logic [LW-1:0] frame_len;
    logic          st_runt, st_giant, st_rxer, st_ovf;
    logic [15:0]   cnt_good, cnt_bad;

    eth_rx_frame_writer #(.MIN_LEN(MINL), .MAX_LEN(MAXL), .LEN_W(LW), .DONE_DELAY(D)) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .fifo_din(fifo_din), .fifo_we(fifo_we), .fifo_full(fifo_full),
        .frame_done(frame_done), .frame_len(frame_len),
        .st_runt(st_runt), .st_giant(st_giant), .st_rxer(st_rxer), .st_ovf(st_ovf),
        .cnt_good(cnt_good), .cnt_bad(cnt_bad)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_we_cyc = -1;
    logic [LW-1:0] snap_len = '0;
    logic [3:0]    snap_st = 4'd0;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (fifo_we) begin
            got_q.push_back(fifo_din);
            last_we_cyc <= cyc;
        end
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            snap_len <= frame_len;
            snap_st  <= {st_runt, st_giant, st_rxer, st_ovf};
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_good = 0;
    int exp_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic full);
        rx_dv = dv; rxd = d; rx_er = er; fifo_full = full;
        tick();
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic chk_stats(input string tag);
`ifdef ETH_RX_STATS_EN
        chk({tag, "_cnt_good"}, {16'd0, cnt_good}, exp_good);
        chk({tag, "_cnt_bad"}, {16'd0, cnt_bad}, exp_bad);
`else
        chk({tag, "_cnt_good"}, {16'd0, cnt_good}, 0);
        chk({tag, "_cnt_bad"}, {16'd0, cnt_bad}, 0);
`endif
    endtask

    // One frame: npre preamble bytes, SFD, n data bytes; fifo_full on bytes [fs, fs+fl); rx_er on byte er_i
    task automatic send_frame(input string nm, input int npre, input int n, input int fs,
                              input int fl, input int er_i);
        int d0, end_c, exp_len, bad_idx;
        logic [7:0] b;
        logic f, e, any_er, any_full, last_wr;
        logic [3:0] est;
        got_q.delete(); exp_q.delete();
        any_er = 1'b0; any_full = 1'b0; last_wr = 1'b0;
        repeat (npre) drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'hD5, 1'b0, 1'b0);
        d0 = done_cnt;
        for (int i = 1; i <= n; i++) begin
            b = 8'($urandom);
            f = (i >= fs) && (i < fs + fl);
            e = (i == er_i);
            drive(1'b1, b, e, f);
            any_full |= f;
            any_er   |= e;
            if (!f && i <= MAXL) exp_q.push_back(b);
            last_wr = !f && (i <= MAXL);
        end
        end_c = cyc + 1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < D + 6 && done_cnt == d0; k++) idle(1);
        exp_len = (n > 2047) ? 2047 : n;
        est = {(exp_len < MINL), (n > MAXL), any_er, any_full};
        if (est == 4'd0) exp_good++; else exp_bad++;
        chk({nm, "_done_count"}, done_cnt - d0, 1);
        chk({nm, "_done_cycle"}, done_cyc, end_c - 1 + D);
        if (last_wr) chk({nm, "_last_write_cycle"}, last_we_cyc, end_c - 1);
        chk({nm, "_frame_len"}, {21'd0, snap_len}, exp_len);
        chk({nm, "_status"}, {28'd0, snap_st}, {28'd0, est});
        chk({nm, "_write_count"}, got_q.size(), exp_q.size());
        bad_idx = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad_idx < 0 && got_q[i] !== exp_q[i]) bad_idx = i;
        chk({nm, "_first_bad_byte_idx"}, bad_idx, -1);
        chk_stats(nm);
        idle(1);
        chk({nm, "_done_pulse_width"}, {31'd0, frame_done}, 0);
        chk({nm, "_len_held"}, {21'd0, frame_len}, exp_len);
        idle(12);
    endtask

    // Malformed preamble: no writes and no done until rx_dv drops
    task automatic bad_pre(input string nm, input logic [7:0] b0, input logic [7:0] b1);
        int d0, w0;
        d0 = done_cnt; w0 = got_q.size();
        drive(1'b1, b0, 1'b0, 1'b0);
        drive(1'b1, b1, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        idle(D + 8);
        chk({nm, "_no_done"}, done_cnt, d0);
        chk({nm, "_no_writes"}, got_q.size(), w0);
    endtask

    initial begin
        int d0, w0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_fifo_we", {31'd0, fifo_we}, 0);
        chk("rst_fifo_din", {24'd0, fifo_din}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_frame_len", {21'd0, frame_len}, 0);
        chk("rst_status", {28'd0, st_runt, st_giant, st_rxer, st_ovf}, 0);
        chk_stats("rst");
        rst = 1'b0;
        idle(5);

        send_frame("normal", 7, 64, 0, 0, 0);
        send_frame("runt", 7, 40, 0, 0, 0);
        send_frame("giant", 7, 1600, 0, 0, 0);
        send_frame("ovf", 7, 100, 50, 3, 0);
        send_frame("rxer", 7, 70, 0, 0, 10);
        send_frame("zero_len", 7, 0, 0, 0, 0);
        bad_pre("bad_pre_second", 8'h55, 8'h12);
        bad_pre("bad_pre_first", 8'h12, 8'h55);

        // Reset pulse mid-frame at byte 30
        d0 = done_cnt;
        repeat (7) drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 1; i < 30; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        rx_dv = 1'b1; rxd = 8'hA5; rst = 1'b1;
        #1;
        chk("midrst_fifo_we", {31'd0, fifo_we}, 0);
        chk("midrst_frame_len", {21'd0, frame_len}, 0);
        chk("midrst_status", {28'd0, st_runt, st_giant, st_rxer, st_ovf}, 0);
        exp_good = 0; exp_bad = 0;
        tick();
        rst = 1'b0;
        w0 = got_q.size();
        for (int i = 31; i <= 70; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        idle(D + 8);
        chk("midrst_no_writes", got_q.size(), w0);
        chk("midrst_no_done", done_cnt, d0);
        chk_stats("midrst");

        send_frame("after_rst", 7, 64, 0, 0, 0);
        send_frame("saturate", 3, 2100, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            int n, fs, fl, er_i;
            n    = $urandom_range(200, 0);
            fs   = $urandom_range(n + 1, 1);
            fl   = $urandom_range(4, 0);
            er_i = $urandom_range(n, 0);
            send_frame($sformatf("rand%0d", r), $urandom_range(7, 1), n, fs, fl, er_i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
